// File: rtl/render_sched_if.sv
// Frame-scheduler bus: trigger/handshake inputs from the video and render
// pipeline, and control/status outputs from the scheduler.
interface render_sched_if #(
   parameter int WIIA = 4,
   parameter int WIFA = 8
);
   logic                   run;
   logic                   frame_tick;
   logic [WIIA+WIFA-1:0]   angle_step;
   logic                   proj_done;
   logic                   fifo_empty;
   logic                   raster_idle;
   logic                   list_rewind;
   logic                   proj_start;
   logic                   buf_swap;
   logic [WIIA+WIFA-1:0]   angle;
   logic                   busy;
   logic [15:0]            frame_count;
   logic                   overrun;

   modport slave (
      input  run, frame_tick, angle_step, proj_done, fifo_empty, raster_idle,
      output list_rewind, proj_start, buf_swap, angle, busy, frame_count, overrun
   );

   modport master (
      output run, frame_tick, angle_step, proj_done, fifo_empty, raster_idle,
      input  list_rewind, proj_start, buf_swap, angle, busy, frame_count, overrun
   );
endinterface

// File: rtl/render_sched.sv
// Per-frame render scheduler: rewinds the triangle list, runs projection,
// drains the raster pipe, then swaps buffers and advances the rotation angle.
module render_sched #(
   parameter int                    WIIA       = 4,
   parameter int                    WIFA       = 8,
   parameter logic [WIIA+WIFA-1:0]  ANGLE_WRAP = 12'h648
) (
   input  logic           Clk,
   input  logic           Reset,
   render_sched_if.slave  bus
);
   localparam int W = WIIA + WIFA;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REWIND,
      S_PROJECT,
      S_RELEASE,
      S_DRAIN,
      S_SWAP
   } state_t;

   state_t          state_q, state_d;
   logic            list_rewind_q, proj_start_q, buf_swap_q, busy_q, overrun_q;
   logic [W-1:0]    angle_q, angle_d;
   logic [15:0]     frame_cnt;
   logic [W:0]      sum, diff;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (bus.frame_tick && bus.run)          state_d = S_REWIND;
         S_REWIND:                                          state_d = S_PROJECT;
         S_PROJECT: if (bus.proj_done)                      state_d = S_RELEASE;
         S_RELEASE: if (!bus.proj_done)                     state_d = S_DRAIN;
         S_DRAIN:   if (bus.fifo_empty && bus.raster_idle)  state_d = S_SWAP;
         S_SWAP:                                            state_d = S_IDLE;
         default:                                           state_d = S_IDLE;
      endcase
   end

   // One conditional subtract suffices since both operands are below the modulus.
   always_comb begin
      sum     = {1'b0, angle_q} + {1'b0, bus.angle_step};
      diff    = sum - {1'b0, ANGLE_WRAP};
      angle_d = (sum >= {1'b0, ANGLE_WRAP}) ? diff[W-1:0] : sum[W-1:0];
   end

   // Outputs are registered off the next state so they align exactly with the state.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q       <= S_IDLE;
         list_rewind_q <= 1'b0;
         proj_start_q  <= 1'b0;
         buf_swap_q    <= 1'b0;
         busy_q        <= 1'b0;
         overrun_q     <= 1'b0;
         angle_q       <= '0;
         frame_cnt     <= '0;
      end else begin
         state_q       <= state_d;
         list_rewind_q <= (state_d == S_REWIND);
         proj_start_q  <= (state_d == S_PROJECT);
         buf_swap_q    <= (state_d == S_SWAP);
         busy_q        <= (state_d != S_IDLE);
         if (state_q == S_SWAP) begin
            angle_q   <= angle_d;
            frame_cnt <= frame_cnt + 16'd1;
         end
         if (bus.frame_tick && (state_q != S_IDLE))
            overrun_q <= 1'b1;
      end
   end

   assign bus.list_rewind = list_rewind_q;
   assign bus.proj_start  = proj_start_q;
   assign bus.buf_swap    = buf_swap_q;
   assign bus.busy        = busy_q;
   assign bus.angle       = angle_q;
   assign bus.frame_count = frame_cnt;
   assign bus.overrun     = overrun_q;
endmodule

// File: doc/render_sched.md
RENDER_SCHED -- requirements
Module: render_sched

Interface
REQ-001 Parameter WIIA, default 4, integer bits of the angle.
REQ-002 Parameter WIFA, default 8, fractional bits of the angle.
REQ-003 Parameter ANGLE_WRAP, default 12'h648 (2*pi in Q4.8), modulus for the angle.
REQ-004 Clk  input  1  single clock; all logic on posedge Clk.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 run  input  1  level; 1 = accept frame triggers.
REQ-007 frame_tick  input  1  one-cycle pulse at start of vertical blank.
REQ-008 angle_step  input  WIIA+WIFA  per-frame angle increment (unsigned), sampled in Swap.
REQ-009 proj_done  input  1  level from projection engine; high while it sits in its Done state.
REQ-010 fifo_empty  input  1  projected-triangle FIFO empty.
REQ-011 raster_idle  input  1  rasterizer has no triangle in flight.
REQ-012 list_rewind  output  1  one-cycle pulse; resets the triangle-list read pointer.
REQ-013 proj_start  output  1  level request to projection engine.
REQ-014 buf_swap  output  1  one-cycle pulse; swaps front/back frame buffers.
REQ-015 angle  output  WIIA+WIFA  current rotation angle fed to projection.
REQ-016 busy  output  1  high in every state except Idle.
REQ-017 frame_count  output  16  frames completed; wraps 16'hFFFF -> 0.
REQ-018 overrun  output  1  sticky; set when a frame_tick is dropped.

Function
REQ-019 The FSM SHALL have states Idle, Rewind, Project, Release, Drain and Swap.
REQ-020 Idle: on frame_tick=1 and run=1 -> Rewind; otherwise stay.
REQ-021 Rewind: list_rewind=1 for exactly this cycle; -> Project.
REQ-022 Project: proj_start=1; on proj_done=1 -> Release; otherwise stay, with no timeout.
REQ-023 Release: proj_start=0; stay until proj_done=0, then -> Drain; this guarantees the engine has returned to its wait state before any restart.
REQ-024 Drain: stay until fifo_empty=1 and raster_idle=1 in the same cycle, then -> Swap.
REQ-025 Swap: buf_swap=1 for exactly this cycle, angle updates, frame_count increments; -> Idle.
REQ-026 proj_start SHALL be a registered output, high exactly in the cycles the FSM is in Project; list_rewind and buf_swap are likewise registered, one cycle each.
REQ-027 Angle update: sum = angle + angle_step computed at WIIA+WIFA+1 bits; if sum >= ANGLE_WRAP then angle <= sum - ANGLE_WRAP, else angle <= sum.
REQ-028 angle_step >= ANGLE_WRAP is a caller error; the result is unspecified.
REQ-029 angle SHALL remain stable from Rewind through Drain, so projection sees one angle per frame.
REQ-030 A frame_tick in any state other than Idle SHALL be dropped: no queuing, overrun <= 1.
REQ-031 overrun SHALL clear only on Reset.
REQ-032 A frame_tick in Idle with run=0 SHALL be ignored silently and SHALL NOT set overrun.
REQ-033 Clearing run mid-frame SHALL NOT abort the frame; the FSM completes through Swap.
REQ-034 When frame_tick arrives in the same cycle as the Swap->Idle transition, it SHALL be dropped and overrun set, because the FSM is not yet in Idle.
REQ-035 Latency: frame_tick to list_rewind is 1 cycle; list_rewind to first proj_start is 1 cycle.

Reset
REQ-036 Reset SHALL force the Idle state with proj_start=0, list_rewind=0, buf_swap=0, busy=0, angle=0, frame_count=0 and overrun=0.
REQ-037 Reset asserted mid-frame SHALL take effect at the next edge regardless of state.
REQ-038 Reset SHALL drop proj_start the following cycle; the projection engine is reset by the same Reset.

Verification
REQ-039 run=1, single frame_tick, proj_done high 20 cycles after proj_start then low, fifo_empty=raster_idle=1:
  - list_rewind 1 cycle after the tick; proj_start high exactly until proj_done.
  - buf_swap pulses once; frame_count=1; angle=angle_step.
REQ-040 angle=12'h640, angle_step=12'h010:
  - after Swap, angle=12'h008 (1616-1608).
  - with step 12'h008, angle=12'h000 exactly.
REQ-041 Second frame_tick while in Project:
  - overrun=1; only one buf_swap; frame_count=1.
REQ-042 proj_done held high 5 cycles after proj_start drops:
  - FSM stays in Release 5 cycles; proj_start stays 0; no Drain before proj_done=0.
REQ-043 fifo_empty=0 for 50 cycles in Drain, raster_idle toggling:
  - Swap only in the first cycle both are 1.
  - Reset asserted during Drain returns all outputs to REQ-036 values next cycle.
REQ-044 run=0 with frame_tick:
  - no state change; overrun stays 0.
  - frame_count wraps 16'hFFFF -> 0 after one more frame.
